data_mem_ext: RTL

DATA_MEM_EXT -- requirements
Module: data_mem_ext

---
 rtl/data_mem_ext_pkg.sv | 40 ++++
 rtl/data_mem_ext_ext.sv | 50 +++++
 rtl/data_mem_ext.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_ext_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ext_pkg
//  Purpose  : Shared constants for the data memory block.
//             - DMSel access-type encodings
//             - Clear/ready FSM state encoding
//             - Misalignment helper shared by the load/store flag logic
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package data_mem_ext_pkg;

    // Access types carried on DMSel
    localparam logic [2:0] DMW  = 3'd0;  // word
    localparam logic [2:0] DMH  = 3'd1;  // halfword, sign-extended
    localparam logic [2:0] DMHU = 3'd2;  // halfword, zero-extended
    localparam logic [2:0] DMB  = 3'd3;  // byte, sign-extended
    localparam logic [2:0] DMBU = 3'd4;  // byte, zero-extended

    // Clear sequencer states
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dm_state_t;

    // True when an access of type sel at byte offset off is not naturally
    // aligned. Byte accesses are always aligned.
    function automatic logic is_misaligned(input logic [2:0] sel,
                                           input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (sel == DMW)
            mis = (off != 2'b00);
        else if ((sel == DMH) || (sel == DMHU))
            mis = off[0];
        return mis;
    endfunction

endpackage : data_mem_ext_pkg
`default_nettype wire

// File: rtl/data_mem_ext_ext.sv
`default_nettype none
// ============================================================================
//  Module   : dm_ext_unit
//  Purpose  : Combinational load path: picks the byte lane(s) addressed by
//             the low address bits out of a 32-bit word and sign- or
//             zero-extends them according to the access type.
//  Ports    : word     in  32  raw word read from the array
//             sel      in  3   access type (DMW/DMH/DMHU/DMB/DMBU)
//             byte_off in  2   byte offset within the word (Addr[1:0])
//             ext      out 32  extended load data
//  Revision : 1.0 - initial release
// ============================================================================
module dm_ext_unit
    import data_mem_ext_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  sel,
    input  logic [1:0]  byte_off,
    output logic [31:0] ext
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Halfword chosen by Addr[1]; byte chosen by Addr[1:0]
    always_comb begin
        w_half = byte_off[1] ? word[31:16] : word[15:0];
        w_byte = 8'h00;
        case (byte_off)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
    end

    always_comb begin
        ext = 32'h0000_0000;
        case (sel)
            DMW:     ext = word;
            DMH:     ext = {{16{w_half[15]}}, w_half};
            DMHU:    ext = {16'h0000, w_half};
            DMB:     ext = {{24{w_byte[7]}}, w_byte};
            DMBU:    ext = {24'h00_0000, w_byte};
            default: ext = 32'h0000_0000;  // undefined access types read as 0
        endcase
    end

endmodule : dm_ext_unit
`default_nettype wire

// File: rtl/data_mem_ext.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ext
//  Purpose  : Word-organised data memory with byte/halfword/word loads and
//             stores, alignment-exception flags and a post-reset clear
//             sequence that zeroes every word before the memory is usable.
//  Ports    : clk    in  1       clock, rising edge
//             reset  in  1       synchronous active-high; starts the clear
//             DWE    in  1       store request
//             DMSel  in  3       access type (W/H/HU/B/BU)
//             Addr   in  ADDR_W  byte address
//             WD     in  32      store data, right-aligned
//             PC     in  32      tag printed in the store trace
//             DMOut  out 32      extended load data (combinational)
//             busy   out 1       high while the clear sequence runs
//             AdEL   out 1       misaligned-load flag (combinational)
//             AdES   out 1       misaligned/illegal-store flag (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_ext
    import data_mem_ext_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              DWE,
    input  logic [2:0]        DMSel,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WD,
    input  logic [31:0]       PC,
    output logic [31:0]       DMOut,
    output logic              busy,
    output logic              AdEL,
    output logic              AdES
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DEPTH_WORDS - 1);

    // ------------------------------------------------------------------
    // Storage and sequencer state
    // ------------------------------------------------------------------
    logic [31:0]      r_mem [DEPTH_WORDS];
    dm_state_t        r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;

    logic             w_in_clear;
    logic [IDX_W-1:0] w_word_idx;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_ext;
    logic             w_mis;
    logic [3:0]       w_be;
    logic [31:0]      w_lane;
    logic [31:0]      w_merged;
    logic             w_store_en;
    logic             w_clear_we;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_mem_idx;
    logic [31:0]      w_mem_wdata;
    logic [ADDR_W-1:0] w_aligned_addr;

    assign w_in_clear     = (r_state == ST_CLEAR);
    // Upper address bits are deliberately dropped so addresses wrap
    assign w_word_idx     = Addr[IDX_W+1:2];
    assign w_aligned_addr = {Addr[ADDR_W-1:2], 2'b00};
    assign w_rd_word      = r_mem[w_word_idx];

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    dm_ext_unit u_ext (
        .word     (w_rd_word),
        .sel      (DMSel),
        .byte_off (Addr[1:0]),
        .ext      (w_ext)
    );

    assign w_mis = is_misaligned(DMSel, Addr[1:0]);

    // All externally visible load/flag outputs are silenced during clear
    assign DMOut = w_in_clear ? 32'h0000_0000 : w_ext;
    assign AdEL  = ~w_in_clear & w_mis;
    // Zero-extending types have no store meaning, so they flag as illegal
    assign AdES  = ~w_in_clear & DWE &
                   ((DMSel == DMHU) | (DMSel == DMBU) | w_mis);
    assign busy  = r_busy;

    // ------------------------------------------------------------------
    // Store merge: replicate the store data across all lanes, then take
    // only the enabled bytes over the current word contents.
    // ------------------------------------------------------------------
    always_comb begin
        w_be   = 4'b0000;
        w_lane = 32'h0000_0000;
        case (DMSel)
            DMW: begin
                w_be   = 4'b1111;
                w_lane = WD;
            end
            DMH: begin
                w_be   = Addr[1] ? 4'b1100 : 4'b0011;
                w_lane = {2{WD[15:0]}};
            end
            DMB: begin
                w_be   = 4'b0001 << Addr[1:0];
                w_lane = {4{WD[7:0]}};
            end
            default: begin
                w_be   = 4'b0000;
                w_lane = 32'h0000_0000;
            end
        endcase
    end

    always_comb begin
        w_merged = w_rd_word;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i])
                w_merged[8*i +: 8] = w_lane[8*i +: 8];
        end
    end

    assign w_store_en = DWE & ~reset & ~w_in_clear & ~AdES & (|w_be);
    assign w_clear_we = ~reset & w_in_clear;

    // Single write port shared by the clear sequencer and stores; the two
    // sources are mutually exclusive because stores require READY.
    assign w_mem_we    = w_clear_we | w_store_en;
    assign w_mem_idx   = w_clear_we ? r_idx : w_word_idx;
    assign w_mem_wdata = w_clear_we ? 32'h0000_0000 : w_merged;

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_idx] <= w_mem_wdata;
    end

    // ------------------------------------------------------------------
    // Clear sequencer. busy is registered alongside the state so it is
    // high for exactly DEPTH_WORDS reset-free cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store trace (simulation only)
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (w_store_en)
            $display("@%08h: *%08h <= %08h", PC, w_aligned_addr, w_merged);
    end
`endif

endmodule : data_mem_ext
`default_nettype wire
